// File: rtl/act_unit_pipe.sv
// act_unit_pipe: multi-lane two-stage activation pipeline (bypass / ReLU / leaky / clipped ReLU)
// with a valid/ready stream interface and a saturating clip-event counter.

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module act_unit_pipe #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned LANES      = 4,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic [1:0]                  in_mode,
    input  logic [DATA_WIDTH-1:0]       in_clip,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [1:0]                  out_mode,
    output logic [CNT_WIDTH-1:0]        clip_cnt,
    input  logic                        clip_cnt_clr
);

    localparam int unsigned VecW = LANES * DATA_WIDTH;

    localparam logic [1:0] ModeBypass = 2'd0;
    localparam logic [1:0] ModeRelu   = 2'd1;
    localparam logic [1:0] ModeLeaky  = 2'd2;

    // Stage 1 state
    logic                         s1_valid_q, s1_valid_d;
    logic [VecW-1:0]              s1_data_q, s1_data_d;
    logic [1:0]                   s1_mode_q, s1_mode_d;
    logic signed [DATA_WIDTH-1:0] s1_clip_q, s1_clip_d;
    logic [LANES-1:0]             s1_neg_q, s1_neg_d;
    logic [LANES-1:0]             s1_gt_q, s1_gt_d;

    // Stage 2 state (drives the outputs directly)
    logic                         s2_valid_q, s2_valid_d;
    logic [VecW-1:0]              out_data_q, out_data_d;
    logic [1:0]                   out_mode_q, out_mode_d;
    logic                         s2_clip_q, s2_clip_d;
    logic [CNT_WIDTH-1:0]         clip_cnt_q, clip_cnt_d;

    logic                         s1_advance;
    logic                         s1_clipped;
    logic                         clip_inc;
    logic signed [DATA_WIDTH-1:0] clip_clamped;
    logic signed [DATA_WIDTH-1:0] lane_x;
    logic signed [DATA_WIDTH-1:0] lane_y;
    logic [VecW-1:0]              act_data;

    // Single combinational ready chain: S2 drains or is empty -> S1 may move -> input may load.
    assign s1_advance = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s1_advance;

    // Per-lane sign flags and clip compares against the clamped (non-negative) ceiling.
    always_comb begin
        clip_clamped = in_clip[DATA_WIDTH-1] ? '0 : in_clip;
        s1_neg_d     = s1_neg_q;
        s1_gt_d      = s1_gt_q;
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        s1_mode_d    = s1_mode_q;
        s1_clip_d    = s1_clip_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_mode_d = in_mode;
                s1_clip_d = clip_clamped;
                for (int i = 0; i < LANES; i++) begin
                    s1_neg_d[i] = in_data[i*DATA_WIDTH + DATA_WIDTH - 1];
                    s1_gt_d[i]  = $signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]) > clip_clamped;
                end
            end
        end
    end

    // Final lane values from the stage-1 flags.
    always_comb begin
        act_data = '0;
        lane_x   = '0;
        lane_y   = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_x = s1_data_q[i*DATA_WIDTH +: DATA_WIDTH];
            case (s1_mode_q)
                ModeBypass: lane_y = lane_x;
                ModeRelu:   lane_y = s1_neg_q[i] ? '0 : lane_x;
                ModeLeaky:  lane_y = s1_neg_q[i] ? (lane_x >>> LEAK_SHIFT) : lane_x;
                default:    lane_y = s1_neg_q[i] ? '0 : (s1_gt_q[i] ? s1_clip_q : lane_x);
            endcase
            act_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_y;
        end
    end

    // A negative lane can never exceed the clamped ceiling, so gt alone marks a clip.
    assign s1_clipped = (s1_mode_q == 2'd3) && (|s1_gt_q);

    // Stage-2 load; holds its beat while the consumer stalls.
    always_comb begin
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_mode_d = out_mode_q;
        s2_clip_d  = s2_clip_q;
        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = act_data;
                out_mode_d = s1_mode_q;
                s2_clip_d  = s1_clipped;
            end
        end
    end

    assign clip_inc = s2_valid_q && out_ready && s2_clip_q;

    // Saturating clip-event counter; clear wins over the old value but keeps a coincident event.
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (clip_cnt_clr) begin
            clip_cnt_d = clip_inc ? CNT_WIDTH'(1) : '0;
        end else if (clip_inc && (clip_cnt_q != '1)) begin
            clip_cnt_d = clip_cnt_q + CNT_WIDTH'(1);
        end
    end

    // All pipeline and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= '0;
            s1_clip_q  <= '0;
            s1_neg_q   <= '0;
            s1_gt_q    <= '0;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            out_mode_q <= '0;
            s2_clip_q  <= 1'b0;
            clip_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s1_clip_q  <= s1_clip_d;
            s1_neg_q   <= s1_neg_d;
            s1_gt_q    <= s1_gt_d;
            s2_valid_q <= s2_valid_d;
            out_data_q <= out_data_d;
            out_mode_q <= out_mode_d;
            s2_clip_q  <= s2_clip_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;
    assign clip_cnt  = clip_cnt_q;

endmodule

// File: tb/tb_act_unit_pipe.sv
// tb_act_unit_pipe: scoreboard bench for act_unit_pipe against an arithmetic reference model.

module tb_act_unit_pipe;

    localparam int DW = 16;
    localparam int LN = 4;
    localparam int LS = 3;
    localparam int CW = 4;
    localparam int VW = DW * LN;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic [1:0]    in_mode;
    logic [DW-1:0] in_clip;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic [1:0]    out_mode;
    logic [CW-1:0] clip_cnt;
    logic          clip_cnt_clr;

    act_unit_pipe #(
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .LEAK_SHIFT (LS),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_mode      (in_mode),
        .in_clip      (in_clip),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_mode     (out_mode),
        .clip_cnt     (clip_cnt),
        .clip_cnt_clr (clip_cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] data;
        logic [1:0]    mode;
        bit            clipped;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference activation on plain integers; leaky is floor division by 2^LS.
    function automatic int ref_act(int x, int m, int c);
        int cc;
        cc = (c < 0) ? 0 : c;
        case (m)
            1:       return (x < 0) ? 0 : x;
            2:       return (x < 0) ? -((-x + (1 << LS) - 1) / (1 << LS)) : x;
            3:       return (x < 0) ? 0 : ((x > cc) ? cc : x);
            default: return x;
        endcase
    endfunction

    function automatic logic [VW-1:0] pack4(int l0, int l1, int l2, int l3);
        logic [VW-1:0] v;
        logic [31:0]   a, b, c, d;
        a = l0; b = l1; c = l2; d = l3;
        v = {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_lane();
        logic [31:0] r;
        case ($urandom % 8)
            0:       r = 32'hFFFF_8000;
            1:       r = 32'h0000_7FFF;
            2:       r = $urandom_range(20, 0) - 10;
            default: r = $urandom;
        endcase
        return r[DW-1:0];
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LN; i++) v[i*DW +: DW] = rand_lane();
        return v;
    endfunction

    // Monitor/scoreboard: sees the transfers that the next rising edge will perform.
    logic          prev_stall = 1'b0;
    logic [VW-1:0] prev_data;
    logic [1:0]    prev_mode;

    always @(negedge clk) begin
        exp_t e;
        bit   inc;
        int   x, c, r;
        if (!rst_n) begin
            q.delete();
            model_cnt  = 0;
            prev_stall = 1'b0;
        end else begin
            chk(clip_cnt == CW'(model_cnt), "clip_cnt", 64'(clip_cnt), 64'(model_cnt));
            if (prev_stall) begin
                chk(out_valid === 1'b1, "stall_valid_hold", 64'(out_valid), 64'd1);
                chk(out_data === prev_data && out_mode === prev_mode, "stall_data_hold",
                    out_data, prev_data);
            end
            inc = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", out_data, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk(out_data === e.data, "out_data", out_data, e.data);
                    chk(out_mode === e.mode, "out_mode", 64'(out_mode), 64'(e.mode));
                    inc = e.clipped;
                end
            end
            if (in_valid && in_ready) begin
                e.mode    = in_mode;
                e.clipped = 1'b0;
                e.data    = '0;
                c = int'($signed(in_clip));
                for (int i = 0; i < LN; i++) begin
                    x = int'($signed(in_data[i*DW +: DW]));
                    r = ref_act(x, int'(in_mode), c);
                    e.data[i*DW +: DW] = r[DW-1:0];
                    if (in_mode == 2'd3 && x > ((c < 0) ? 0 : c)) e.clipped = 1'b1;
                end
                q.push_back(e);
            end
            if (clip_cnt_clr) model_cnt = inc ? 1 : 0;
            else if (inc && model_cnt != (1 << CW) - 1) model_cnt = model_cnt + 1;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_mode  = out_mode;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [VW-1:0] d, input logic [1:0] m,
                             input logic [DW-1:0] c);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_clip  = c;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else @(posedge clk);
        end
        if (!acc) chk(1'b0, "accept_timeout", 64'd0, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            tick();
            n++;
        end
        chk(q.size() == 0 && !out_valid, "drain", 64'(q.size()), 64'd0);
    endtask

    // Hard time limit in case the DUT wedges the stimulus.
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int sent, cyc, seen;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_mode      = '0;
        in_clip      = '0;
        out_ready    = 1'b1;
        clip_cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(out_valid === 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        chk(out_data === '0, "rst_out_data", out_data, 64'd0);
        chk(out_mode === 2'd0, "rst_out_mode", 64'(out_mode), 64'd0);
        chk(clip_cnt === '0, "rst_clip_cnt", 64'(clip_cnt), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk(in_ready === 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // ReLU with latency and single-pulse check
        send_beat(pack4(-32768, 7, 0, -5), 2'd1, 16'd0);
        @(negedge clk);
        chk(out_valid === 1'b0, "relu_latency_s1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk(out_valid === 1'b1, "relu_latency_s2", 64'(out_valid), 64'd1);
        chk(out_data === pack4(0, 7, 0, 0), "relu_value", out_data, pack4(0, 7, 0, 0));
        @(negedge clk);
        chk(out_valid === 1'b0, "relu_pulse", 64'(out_valid), 64'd0);
        drain();

        // Leaky ReLU floors toward -inf
        send_beat(pack4(100, -64, -9, -1), 2'd2, 16'd0);
        @(negedge clk);
        @(negedge clk);
        chk(out_data === pack4(100, -8, -2, -1), "leaky_value", out_data,
            pack4(100, -8, -2, -1));
        drain();

        // Clipped ReLU, positive then negative ceiling
        send_beat(pack4(-2, 7, 6, 3), 2'd3, 16'd6);
        drain();
        chk(clip_cnt === 4'd1, "clip_cnt_first", 64'(clip_cnt), 64'd1);
        send_beat(pack4(1, 1, 0, 5), 2'd3, 16'hFFFC);
        drain();
        chk(clip_cnt === 4'd2, "clip_cnt_neg_ceiling", 64'(clip_cnt), 64'd2);

        // Eight back-to-back beats with a mid-stream consumer stall
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(rand_vec(), 2'(i % 4), rand_lane());
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                chk(in_ready === 1'b0, "full_in_ready_low", 64'(in_ready), 64'd0);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random valid/ready traffic
        acc  = 1'b0;
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            tick();
            out_ready = 1'($urandom % 2);
            if (!in_valid || acc) begin
                if ($urandom % 2 == 0) begin
                    in_valid = 1'b1;
                    in_data  = rand_vec();
                    in_mode  = 2'($urandom % 4);
                    in_clip  = rand_lane();
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
            cyc++;
        end
        chk(sent == 1000, "random_sent", 64'(sent), 64'd1000);
        tick();
        in_valid = 1'b0;
        drain();

        // Clear alone, then saturation
        clip_cnt_clr = 1'b1;
        tick();
        clip_cnt_clr = 1'b0;
        chk(clip_cnt === 4'd0, "clr_alone", 64'(clip_cnt), 64'd0);
        for (int i = 0; i < 17; i++) send_beat(pack4(1, 2, 3, 4), 2'd3, 16'd0);
        drain();
        chk(clip_cnt === 4'd15, "clip_cnt_saturate", 64'(clip_cnt), 64'd15);

        // Clear coincident with a clip event
        out_ready = 1'b0;
        send_beat(pack4(9, 0, 0, 0), 2'd3, 16'd3);
        seen = 0;
        for (int n = 0; n < 20 && seen == 0; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk(seen == 1, "clr_inc_wait", 64'(seen), 64'd1);
        tick();
        out_ready    = 1'b1;
        clip_cnt_clr = 1'b1;
        tick();
        clip_cnt_clr = 1'b0;
        chk(clip_cnt === 4'd1, "clr_with_inc", 64'(clip_cnt), 64'd1);
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send_beat(rand_vec(), 2'd0, 16'd0);
        send_beat(rand_vec(), 2'd1, 16'd0);
        rst_n = 1'b0;
        #1;
        chk(out_valid === 1'b0, "midrst_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk(seen == 0, "midrst_no_stale", 64'(seen), 64'd0);
        chk(in_ready === 1'b1, "midrst_in_ready", 64'(in_ready), 64'd1);
        chk(clip_cnt === 4'd0, "midrst_clip_cnt", 64'(clip_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
